// File: rtl/hilo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hilo_muldiv_unit
//   Iterative MULT/MULTU/DIV/DIVU engine in EX. It produces the HI/LO write
//   bundle that feeds the register-file HI/LO write port and the
//   ex/mem/wb HI/LO bypass buses.
//
//   Multiply: radix-2 shift-add with the accumulator shifting right.
//   Divide  : restoring, one quotient bit per cycle, with the same
//             accumulator shifting left.
//   Signed operations work on magnitudes. The sign fix is folded into the
//   load of hi_o/lo_o.
//
// Ports
//   clk      in   clock; all state changes on the rising edge
//   rst      in   synchronous reset, active high
//   start    in   launch request; sampled only in IDLE
//   op       in   00=MULT 01=MULTU 10=DIV 11=DIVU; sampled with start
//   src_a    in   rs operand (dividend / multiplicand)
//   src_b    in   rt operand (divisor / multiplier)
//   cancel   in   flush; aborts the operation in flight
//   stall_o  out  pipeline stall request
//   busy     out  high in CALC or DONE
//   done     out  one-cycle result-valid pulse
//   hi_we    out  HI write enable (same as done)
//   lo_we    out  LO write enable (same as done)
//   hi_o     out  product high half or remainder
//   lo_o     out  product low half or quotient
// ---------------------------------------------------------------------------
module hilo_muldiv_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] DIV0_QUOT = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             stall_o,
    output logic             busy,
    output logic             done,
    output logic             hi_we,
    output logic             lo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;    // mul: {partial hi, multiplier}; div: {rem, dividend/quot}
    logic [WIDTH-1:0]   r_mag;    // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_q;  // negate product / quotient
    logic               r_neg_r;  // negate remainder
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    // Launch-time operand decode
    logic             w_sa;
    logic             w_sb;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_sa    = ~op[0] & src_a[WIDTH-1];
    assign w_sb    = ~op[0] & src_b[WIDTH-1];
    assign w_mag_a = w_sa ? -src_a : src_a;
    assign w_mag_b = w_sb ? -src_b : src_b;

    // Multiply step: add the multiplicand into the high half when the current
    // multiplier bit is set. Then shift the whole accumulator right by one,
    // keeping the carry.
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mag} : {(WIDTH+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: bring the next dividend bit into the remainder and do a
    // trial subtract. Because rem < divisor, the (WIDTH+1)-bit difference
    // has its top bit set exactly when the subtract borrows.
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_borrow;
    logic [2*WIDTH-1:0] w_div_nxt;

    assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_shift - {1'b0, r_mag};
    assign w_borrow  = w_diff[WIDTH];
    assign w_div_nxt = {(w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], ~w_borrow};

    logic [2*WIDTH-1:0] w_acc_nxt;
    assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

    // Sign correction of the final step, loaded into hi_o/lo_o on DONE entry
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        w_prod   = r_neg_q ? -w_acc_nxt : w_acc_nxt;
        w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            w_hi_fix = r_neg_r ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];
            w_lo_fix = r_neg_q ? -w_acc_nxt[WIDTH-1:0]       : w_acc_nxt[WIDTH-1:0];
        end
    end

    logic w_last;
    assign w_last = (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mag    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !cancel) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_cnt    <= '0;
                        if (op[1] && (src_b == '0)) begin
                            // Divide by zero: no iterations, fixed result
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_hi    <= src_a;
                            r_lo    <= DIV0_QUOT;
                        end else begin
                            r_state <= S_CALC;
                            r_mag   <= op[1] ? w_mag_b : w_mag_a;
                            r_acc   <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        end
                    end
                end
                S_CALC: begin
                    if (cancel) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_acc_nxt;
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                            r_hi    <= w_hi_fix;
                            r_lo    <= w_lo_fix;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // A cancel in DONE must squash the write in the same cycle.
    assign done    = r_done & ~cancel;
    assign hi_we   = done;
    assign lo_we   = done;
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;
    assign busy    = (r_state != S_IDLE);
    assign stall_o = ((r_state == S_IDLE) & start & ~cancel) | (r_state == S_CALC);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stall_o;
    logic        busy;
    logic        done;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    hilo_muldiv_unit #(.WIDTH(32), .DIV0_QUOT(32'hFFFF_FFFF)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a),
        .src_b(src_b), .cancel(cancel), .stall_o(stall_o), .busy(busy),
        .done(done), .hi_we(hi_we), .lo_we(lo_we), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Count every result pulse seen mid-cycle
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Launch at cycle T (the current cycle) and wait for done; checks latency,
    // stall coverage, result and hold behaviour.
    task automatic run_op(input string tag, input logic [1:0] op_i,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi_e, input logic [31:0] lo_e,
                          input int lat_e);
        int lat;
        int bad;
        op = op_i; src_a = a; src_b = b; start = 1'b1;
        #1;
        chk({tag, " stall@T"}, stall_o, 1);
        tick();
        start = 1'b0;
        lat = 1;
        bad = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (stall_o !== 1'b1) bad++;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, lat_e);
        chk({tag, " stall in calc"}, bad, 0);
        chk({tag, " hi_o"}, hi_o, hi_e);
        chk({tag, " lo_o"}, lo_o, lo_e);
        chk({tag, " we"}, {hi_we, lo_we}, 2'b11);
        chk({tag, " stall@done"}, stall_o, 0);
        tick();
        chk({tag, " done one cycle"}, {done, busy}, 2'b00);
        chk({tag, " hold"}, {hi_o, lo_o}, {hi_e, lo_e});
    endtask

    initial begin
        int d0;
        int lat;
        rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; cancel = 1'b0;
        tick();
        tick();
        chk("reset outs", {done, hi_we, lo_we, busy, stall_o}, 5'b0);
        chk("reset hilo", {hi_o, lo_o}, 64'h0);
        rst = 1'b0;
        tick();

        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        run_op("mult -3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        run_op("div -7/2",  2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        run_op("divu /0",   2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1);
        run_op("div ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);
        run_op("mult -5x-6", 2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30, 33);

        // Cancel in CALC at T+10, then a fresh MULTU at T+11 finishing at T+44
        d0 = done_cnt;
        op = 2'b10; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        cancel = 1'b1;
        #1;
        chk("cancel calc done", done, 0);
        tick();
        cancel = 1'b0;
        chk("cancel busy", busy, 0);
        run_op("post-cancel multu", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 33);
        repeat (5) tick();
        chk("cancel single done", done_cnt - d0, 1);

        // Start again while busy: ignored (a div-by-zero would answer at once)
        op = 2'b01; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        op = 2'b11; src_a = 32'd9; src_b = 32'd0; start = 1'b1;
        #1;
        chk("restart stall", stall_o, 1);
        tick();
        start = 1'b0;
        lat = 6;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        chk("restart latency", lat, 33);
        chk("restart result", {hi_o, lo_o}, {32'd0, 32'd30});
        tick();
        d0 = done_cnt;
        repeat (40) tick();
        chk("restart no 2nd done", done_cnt - d0, 0);

        // Reset mid-operation at T+20
        op = 2'b00; src_a = 32'hFFFF_FFFD; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst outs", {done, hi_we, lo_we, busy, stall_o}, 5'b0);
        chk("midrst hilo", {hi_o, lo_o}, 64'h0);
        d0 = done_cnt;
        repeat (40) tick();
        chk("midrst no done", done_cnt - d0, 0);

        // cancel together with start in IDLE
        op = 2'b01; src_a = 32'd1; src_b = 32'd1; start = 1'b1; cancel = 1'b1;
        #1;
        chk("idle cancel stall", stall_o, 0);
        tick();
        start = 1'b0; cancel = 1'b0;
        chk("idle cancel busy", {busy, done}, 2'b00);

        // cancel in DONE squashes the write
        d0 = done_cnt;
        op = 2'b11; src_a = 32'd55; src_b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b1;
        #1;
        chk("done cancel we", {done, hi_we, lo_we}, 3'b000);
        chk("done cancel busy", busy, 1);
        tick();
        cancel = 1'b0;
        chk("done cancel idle", {busy, done}, 2'b00);
        chk("done cancel count", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
